// File: rtl/led_switch_ctrl.sv
// Front-panel LED/switch controller: debounces active-low test switches and
// drives each LED from a mode field, with switch-press and lamp-test override.
module led_switch_ctrl #(
  parameter int num_io         = 1,
  parameter int prescale       = 50000,
  parameter int debounce_ticks = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:num_io-1]   test_switch,
  input  logic [0:2*num_io-1] led_mode,
  input  logic                lamp_test,
  output logic [0:num_io-1]   test_led,
  output logic [0:num_io-1]   sw_state,
  output logic [0:num_io-1]   sw_press
);

  localparam logic [15:0] PRESC_LAST = 16'(prescale - 1);
  localparam logic [7:0]  DB_TARGET  = 8'(debounce_ticks);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } db_state_t;

  logic [15:0]       presc_q, presc_d;
  logic [3:0]        blink_q, blink_d;
  logic              tick_s;
  logic [0:num_io-1] sync1_q, sync2_q;
  logic [0:num_io-1] pressed_raw_s;
  db_state_t         db_state_q [num_io];
  db_state_t         db_state_d [num_io];
  logic [7:0]        db_cnt_q   [num_io];
  logic [7:0]        db_cnt_d   [num_io];
  logic [0:num_io-1] sw_state_q, sw_state_d;
  logic [0:num_io-1] sw_press_q, sw_press_d;
  logic [0:num_io-1] led_q, led_d;
  logic [1:0]        mode_s;
  logic [7:0]        cnt_inc_s;

  always_comb begin
    tick_s        = (presc_q == PRESC_LAST);
    presc_d       = tick_s ? 16'd0 : presc_q + 16'd1;
    blink_d       = tick_s ? blink_q + 4'd1 : blink_q;
    pressed_raw_s = ~sync2_q;
    mode_s        = 2'b00;
    cnt_inc_s     = 8'd0;
    for (int i = 0; i < num_io; i++) begin
      db_state_d[i] = db_state_q[i];
      db_cnt_d[i]   = db_cnt_q[i];
      sw_state_d[i] = sw_state_q[i];
      sw_press_d[i] = 1'b0;
      cnt_inc_s     = db_cnt_q[i] + 8'd1;
      case (db_state_q[i])
        ST_IDLE: begin
          if (pressed_raw_s[i] != sw_state_q[i]) begin
            db_state_d[i] = ST_CHECK;
            db_cnt_d[i]   = 8'd0;
          end else begin
            db_state_d[i] = ST_IDLE;
          end
        end
        ST_CHECK: begin
          // A bounce back to the accepted level aborts, even on a tick cycle.
          if (pressed_raw_s[i] == sw_state_q[i]) begin
            db_state_d[i] = ST_IDLE;
            db_cnt_d[i]   = 8'd0;
          end else if (tick_s) begin
            if (cnt_inc_s == DB_TARGET) begin
              sw_state_d[i] = pressed_raw_s[i];
              sw_press_d[i] = pressed_raw_s[i];
              db_state_d[i] = ST_IDLE;
              db_cnt_d[i]   = 8'd0;
            end else begin
              db_cnt_d[i]   = cnt_inc_s;
            end
          end else begin
            db_cnt_d[i]   = db_cnt_q[i];
          end
        end
        default: begin
          db_state_d[i] = ST_IDLE;
          db_cnt_d[i]   = 8'd0;
        end
      endcase

      // Mode MSB sits at the lower (2i) index of the ascending led_mode bus.
      mode_s = {led_mode[2*i], led_mode[2*i+1]};
      if (lamp_test || sw_state_q[i]) begin
        led_d[i] = 1'b1;
      end else begin
        case (mode_s)
          2'b00:   led_d[i] = 1'b0;
          2'b01:   led_d[i] = 1'b1;
          2'b10:   led_d[i] = blink_q[3];
          2'b11:   led_d[i] = blink_q[1];
          default: led_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= 16'd0;
      blink_q    <= 4'd0;
      sync1_q    <= '1;
      sync2_q    <= '1;
      sw_state_q <= '0;
      sw_press_q <= '0;
      led_q      <= '1;
      for (int i = 0; i < num_io; i++) begin
        db_state_q[i] <= ST_IDLE;
        db_cnt_q[i]   <= 8'd0;
      end
    end else begin
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      sync1_q    <= test_switch;
      sync2_q    <= sync1_q;
      sw_state_q <= sw_state_d;
      sw_press_q <= sw_press_d;
      led_q      <= led_d;
      for (int i = 0; i < num_io; i++) begin
        db_state_q[i] <= db_state_d[i];
        db_cnt_q[i]   <= db_cnt_d[i];
      end
    end
  end

  assign test_led = led_q;
  assign sw_state = sw_state_q;
  assign sw_press = sw_press_q;

endmodule
